nios2_sysid_info: RTL
=====================

Name: nios2_sysid_info

Overview:
- Parametrised successor to the Nios II system-ID slave: a read-mostly Avalon-MM information block on the data master.
- Exposes the system ID and build timestamp, plus:
  - a 64-bit free-running uptime counter with atomic low/high snapshot;
  - a byte-writable scratch register;
  - a control register (clear/freeze).
- Firmware uses it to confirm image/hardware match and to take coarse timestamps without a dedicated timer.

Parameters:
- SYSTEM_ID, 32'h0000_0000, value returned at word 0.
- TIMESTAMP, 32'h0000_0000, build timestamp returned at word 1.
- FEATURES, 32'h0000_0000, opaque capability word returned at word 6.
- CNT_W, 64, uptime counter width; legal range 33..64; bits above CNT_W read 0.
- CLK_DIV, 1, clocks per uptime increment; legal range 1..65535.
- SCRATCH_RST, 32'h0000_0000, scratch reset value.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  3  word address
- read  in  1  read strobe
- write  in  1  write strobe
- writedata  in  32  write data
- byteenable  in  4  write byte lanes
- readdata  out  32  registered read data
- readdatavalid  out  1  one-cycle pulse qualifying readdata

Behaviour:
- Reset (asynchronous assert, synchronous release by system):
  - readdata=0, readdatavalid=0;
  - counter=0, prescaler=0, hi_snap=0;
  - scratch=SCRATCH_RST, freeze=0.
- No waitrequest. Every read is accepted in the cycle it is asserted.
- Read latency is fixed at 1: read sampled high at edge N gives readdatavalid=1 with readdata after edge N+1. Back-to-back reads give back-to-back valid pulses.
- readdata holds its last value when readdatavalid=0.
- Register map (word address):
  - 0 ID: RO, returns SYSTEM_ID.
  - 1 TIMESTAMP: RO, returns TIMESTAMP.
  - 2 UPTIME_LO: RO, returns counter[31:0]. The same edge loads hi_snap <= counter[CNT_W-1:32], zero-extended.
  - 3 UPTIME_HI: RO, returns hi_snap. It does not read the live counter.
  - 4 SCRATCH: RW. Written per byteenable lane; lanes with byteenable=0 are unchanged.
  - 5 CONTROL:
    - bit0 CLEAR: write-1 pulse; reads 0.
    - bit1 FREEZE: RW.
    - other bits read 0.
  - 6 FEATURES: RO, returns FEATURES.
  - 7: reserved, reads 0.
- Writes to RO or reserved words are ignored, with no side effects.
- Read and write asserted in the same cycle: the read is serviced and the write is dropped.
- Prescaler:
  - counts 0..CLK_DIV-1 while FREEZE=0;
  - tick=1 on the cycle it equals CLK_DIV-1, then it wraps to 0;
  - CLK_DIV=1 gives a tick every cycle.
  - Counter increments by 1 on tick.
- FREEZE=1 holds both the prescaler and the counter. Reads remain valid.
- CLEAR write zeroes the counter and prescaler on that edge.
  - CLEAR takes priority over a coincident tick.
  - CLEAR does not alter hi_snap.
  - Writing CONTROL with bit0=1 and bit1=1 clears and freezes together.
- Counter wraps from 2^CNT_W-1 to 0 silently; there is no sticky overflow flag.
- Snapshot uses the pre-increment value: a read of word 2 on a tick edge returns the pre-increment counter[31:0], and hi_snap takes the pre-increment high part. The pair is therefore coherent across a low-word carry.
- Reset mid-read: readdatavalid is forced to 0 and the pending read is lost. The master re-issues after reset.

Test Plan:
- After reset, read addresses 0, 1, 6, 7 with SYSTEM_ID=32'h5135_E4DA, TIMESTAMP=32'h4C3A_1B9A, FEATURES=32'h0000_0003 -> readdata 5135E4DA, 4C3A1B9A, 00000003, 00000000. Each readdatavalid comes exactly 1 cycle after its read; 4 consecutive reads give 4 consecutive valid cycles.
- Counter carry coherence (CNT_W=64, CLK_DIV=1): force counter to 64'h0000_0001_FFFF_FFFF, read word 2 on that edge, then word 3 -> 32'hFFFF_FFFF then 32'h0000_0001. A second word-2 read later then word 3 -> low value >= 1, then 32'h0000_0002.
- Scratch: write 32'hA5A5_A5A5 with byteenable 4'b1111, then write 32'h1234_5678 with byteenable 4'b0101, then read -> 32'hA534_A578. A write to word 0 followed by a read of word 0 -> still SYSTEM_ID.
- Prescaler (CLK_DIV=4): clear, run 40 cycles, read word 2 -> 10. Write CONTROL=2 (freeze), wait 100 cycles -> value unchanged. Write CONTROL=1 -> 0 with FREEZE cleared; counting resumes.
- Clear priority: write CONTROL=1 on a tick edge -> word 2 reads 0 or 1 at the next read, never the old value+1. Simultaneous read of word 4 and write of word 4 -> old scratch returned, scratch unchanged.
- Assert reset_n=0 asynchronously between clock edges during a read -> readdatavalid=0 immediately, no valid pulse after release, counter=0, scratch=SCRATCH_RST.

Source files
------------

// File: rtl/nios2_sysid_info.sv
// System-ID information slave: ID/timestamp/features words, 64-bit uptime
// counter with coherent low/high snapshot, byte-writable scratch and control.
module nios2_sysid_info #(
  parameter logic [31:0] SYSTEM_ID   = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP   = 32'h0000_0000,
  parameter logic [31:0] FEATURES    = 32'h0000_0000,
  parameter int unsigned CNT_W       = 64,
  parameter int unsigned CLK_DIV     = 1,
  parameter logic [31:0] SCRATCH_RST = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam logic [15:0] PRE_MAX = 16'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_pre;
  logic [31:0]      r_hi_snap;
  logic [31:0]      r_scratch;
  logic             r_freeze;

  logic        w_wr;
  logic        w_ctrl_wr;
  logic        w_clear;
  logic        w_tick;
  logic [31:0] w_cnt_lo;
  logic [31:0] w_cnt_hi;
  logic [31:0] w_rmux;

  // A read in the same cycle as a write wins; the write is dropped.
  assign w_wr      = write & ~read;
  assign w_ctrl_wr = w_wr && (address == 3'd5) && byteenable[0];
  assign w_clear   = w_ctrl_wr & writedata[0];
  assign w_tick    = ~r_freeze && (r_pre == PRE_MAX);
  assign w_cnt_lo  = r_cnt[31:0];
  assign w_cnt_hi  = 32'(r_cnt >> 32);

  always_comb begin
    w_rmux = '0;
    case (address)
      3'd0: w_rmux = SYSTEM_ID;
      3'd1: w_rmux = TIMESTAMP;
      3'd2: w_rmux = w_cnt_lo;
      3'd3: w_rmux = r_hi_snap;
      3'd4: w_rmux = r_scratch;
      3'd5: w_rmux = {30'b0, r_freeze, 1'b0};
      3'd6: w_rmux = FEATURES;
      default: w_rmux = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
      r_hi_snap     <= '0;
    end else begin
      readdatavalid <= read;
      if (read) begin
        readdata <= w_rmux;
        // Snapshot sees the pre-increment counter, so lo/hi stay coherent.
        if (address == 3'd2) r_hi_snap <= w_cnt_hi;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_pre <= '0;
    end else if (w_clear) begin
      r_cnt <= '0;
      r_pre <= '0;
    end else if (w_tick) begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_pre <= '0;
    end else if (!r_freeze) begin
      r_pre <= r_pre + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_scratch <= SCRATCH_RST;
      r_freeze  <= 1'b0;
    end else begin
      if (w_wr && (address == 3'd4)) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (byteenable[i]) r_scratch[i*8 +: 8] <= writedata[i*8 +: 8];
        end
      end
      if (w_ctrl_wr) r_freeze <= writedata[1];
    end
  end

endmodule
